// File: rtl/decode_stage.sv
// Types shared by the pipeline stages, followed by the MIPS instruction-decode stage:
// register file with writeback bypass, control decode, load-use hazard detection and halt tracking.
package cpu_types_pkg;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ALUOP_W = 4;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [ALUOP_W-1:0] aluop_t;

  localparam aluop_t ALU_SLL  = 4'h0;
  localparam aluop_t ALU_SRL  = 4'h1;
  localparam aluop_t ALU_ADD  = 4'h2;
  localparam aluop_t ALU_SUB  = 4'h3;
  localparam aluop_t ALU_AND  = 4'h4;
  localparam aluop_t ALU_OR   = 4'h5;
  localparam aluop_t ALU_XOR  = 4'h6;
  localparam aluop_t ALU_NOR  = 4'h7;
  localparam aluop_t ALU_SLT  = 4'h8;
  localparam aluop_t ALU_SLTU = 4'h9;
  localparam aluop_t ALU_LUI  = 4'hA;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic link;
    logic halt;
  } wb_ctrl_t;

  typedef struct packed {
    logic dren;
    logic dwen;
    logic beq;
    logic bne;
    logic jr;
  } mem_ctrl_t;

  typedef struct packed {
    aluop_t     aluop;
    logic       alusrc;
    logic [1:0] regdst;
    logic       extop;
  } ex_ctrl_t;
endpackage

module decode_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] instr_in,
  input  logic [31:0] npc_in,
  input  logic        flush,
  input  logic        wb_WEN,
  input  logic [4:0]  wb_wsel,
  input  logic [31:0] wb_wdat,
  input  logic        ex_dREN,
  input  logic [4:0]  ex_wsel,
  output logic [31:0] rdat1,
  output logic [31:0] rdat2,
  output logic [31:0] npc_out,
  output logic [25:0] addr_out,
  output logic [3:0]  WBctrl,
  output logic [4:0]  MEMctrl,
  output logic [7:0]  EXctrl,
  output logic        stall,
  output logic        halted
);

  localparam int unsigned NREGS = 32;

  word_t      regs [NREGS];
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       wb_hit;

  wb_ctrl_t   wb_d;
  mem_ctrl_t  mem_d;
  ex_ctrl_t   ex_d;
  logic       uses_rs;
  logic       uses_rt;
  logic       r_alu;
  aluop_t     r_op;
  logic       i_alu;
  aluop_t     i_op;
  logic       i_zext;
  logic       hazard;
  logic       bubble;

  assign opcode = instr_in[31:26];
  assign rs     = instr_in[25:21];
  assign rt     = instr_in[20:16];
  assign funct  = instr_in[5:0];
  assign wb_hit = wb_WEN && (wb_wsel != 5'd0);

  // Register file; r0 is never written and reads are forced to zero below.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_wsel] <= wb_wdat;
    end
  end

  always_comb begin
    rdat1 = '0;
    rdat2 = '0;
    if (rs != 5'd0) rdat1 = (wb_hit && wb_wsel == rs) ? wb_wdat : regs[rs];
    if (rt != 5'd0) rdat2 = (wb_hit && wb_wsel == rt) ? wb_wdat : regs[rt];
  end

  // Control decode; anything unrecognised leaves every control bit low.
  always_comb begin
    wb_d    = '0;
    mem_d   = '0;
    ex_d    = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    r_alu   = 1'b0;
    r_op    = ALU_ADD;
    i_alu   = 1'b0;
    i_op    = ALU_ADD;
    i_zext  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        r_alu   = 1'b1;
        case (funct)
          F_ADDU: r_op = ALU_ADD;
          F_SUBU: r_op = ALU_SUB;
          F_AND:  r_op = ALU_AND;
          F_OR:   r_op = ALU_OR;
          F_XOR:  r_op = ALU_XOR;
          F_NOR:  r_op = ALU_NOR;
          F_SLT:  r_op = ALU_SLT;
          F_SLTU: r_op = ALU_SLTU;
          F_SLL:  begin r_op = ALU_SLL; uses_rs = 1'b0; end
          F_SRL:  begin r_op = ALU_SRL; uses_rs = 1'b0; end
          F_JR:   begin r_alu = 1'b0; mem_d.jr = 1'b1; end
          default: begin r_alu = 1'b0; uses_rs = 1'b0; uses_rt = 1'b0; end
        endcase
      end
      OP_ADDIU: begin i_alu = 1'b1; i_op = ALU_ADD;  uses_rs = 1'b1; end
      OP_SLTI:  begin i_alu = 1'b1; i_op = ALU_SLT;  uses_rs = 1'b1; end
      OP_SLTIU: begin i_alu = 1'b1; i_op = ALU_SLTU; uses_rs = 1'b1; end
      OP_ANDI:  begin i_alu = 1'b1; i_op = ALU_AND;  i_zext = 1'b1; uses_rs = 1'b1; end
      OP_ORI:   begin i_alu = 1'b1; i_op = ALU_OR;   i_zext = 1'b1; uses_rs = 1'b1; end
      OP_XORI:  begin i_alu = 1'b1; i_op = ALU_XOR;  i_zext = 1'b1; uses_rs = 1'b1; end
      OP_LUI:   begin i_alu = 1'b1; i_op = ALU_LUI;  i_zext = 1'b1; end
      OP_LW: begin
        i_alu         = 1'b1;
        i_op          = ALU_ADD;
        uses_rs       = 1'b1;
        wb_d.memtoreg = 1'b1;
        mem_d.dren    = 1'b1;
      end
      OP_SW: begin
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        mem_d.dwen  = 1'b1;
        ex_d.aluop  = ALU_ADD;
        ex_d.alusrc = 1'b1;
        ex_d.extop  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
        mem_d.beq  = (opcode == OP_BEQ);
        mem_d.bne  = (opcode == OP_BNE);
        ex_d.aluop = ALU_SUB;
        ex_d.extop = 1'b1;
      end
      OP_JAL: begin
        wb_d.regwrite = 1'b1;
        wb_d.link     = 1'b1;
        ex_d.regdst   = 2'b10;
      end
      OP_HALT: wb_d.halt = 1'b1;
      default: ;
    endcase
    if (r_alu) begin
      wb_d.regwrite = 1'b1;
      ex_d.aluop    = r_op;
      ex_d.regdst   = 2'b01;
    end
    if (i_alu) begin
      wb_d.regwrite = 1'b1;
      ex_d.aluop    = i_op;
      ex_d.alusrc   = 1'b1;
      ex_d.regdst   = 2'b00;
      ex_d.extop    = !i_zext;
    end
  end

  assign hazard = ex_dREN && (ex_wsel != 5'd0) &&
                  ((uses_rs && ex_wsel == rs) || (uses_rt && ex_wsel == rt));
  assign bubble = hazard || flush || halted;

  assign stall    = hazard;
  assign npc_out  = npc_in;
  assign addr_out = instr_in[25:0];
  assign WBctrl   = bubble ? 4'b0 : wb_d;
  assign MEMctrl  = bubble ? 5'b0 : mem_d;
  assign EXctrl   = bubble ? 8'b0 : ex_d;

  // Sticky halt: only a HALT that actually advances out of decode sets it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      halted <= 1'b0;
    end else if (ihit && !flush && !hazard && opcode == OP_HALT) begin
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expectations are queued as stimulus is applied
// and popped against the outputs half a cycle away from the clock edge.
module tb_decode_stage;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic [31:0] instr_in;
  logic [31:0] npc_in;
  logic        flush;
  logic        wb_WEN;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic        ex_dREN;
  logic [4:0]  ex_wsel;
  logic [31:0] rdat1;
  logic [31:0] rdat2;
  logic [31:0] npc_out;
  logic [25:0] addr_out;
  logic [3:0]  WBctrl;
  logic [4:0]  MEMctrl;
  logic [7:0]  EXctrl;
  logic        stall;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  localparam int S_R1 = 0, S_R2 = 1, S_WB = 2, S_MEM = 3, S_EX = 4,
                 S_STALL = 5, S_HALT = 6, S_NPC = 7, S_ADDR = 8;

  decode_stage dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .instr_in(instr_in), .npc_in(npc_in),
    .flush(flush), .wb_WEN(wb_WEN), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .rdat1(rdat1), .rdat2(rdat2),
    .npc_out(npc_out), .addr_out(addr_out), .WBctrl(WBctrl), .MEMctrl(MEMctrl),
    .EXctrl(EXctrl), .stall(stall), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [7:0] exv(input aluop_t op, input logic src,
                                     input logic [1:0] dst, input logic ext);
    return {op, src, dst, ext};
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_R1:    return rdat1;
      S_R2:    return rdat2;
      S_WB:    return 32'(WBctrl);
      S_MEM:   return 32'(MEMctrl);
      S_EX:    return 32'(EXctrl);
      S_STALL: return 32'(stall);
      S_HALT:  return 32'(halted);
      S_NPC:   return npc_out;
      default: return 32'(addr_out);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_ctrl(input string tag, input logic [3:0] wb,
                             input logic [4:0] mem, input logic [7:0] ex);
    expect_val({tag, ".wb"},  S_WB,  32'(wb));
    expect_val({tag, ".mem"}, S_MEM, 32'(mem));
    expect_val({tag, ".ex"},  S_EX,  32'(ex));
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] got;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.sel);
      checks++;
      assert (got === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic sweep(input string tag, input logic [31:0] ins, input logic [3:0] wb,
                       input logic [4:0] mem, input logic [7:0] ex);
    instr_in = ins;
    expect_ctrl(tag, wb, mem, ex);
    expect_val({tag, ".stall"}, S_STALL, 32'd0);
    check_all();
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; instr_in = '0; npc_in = '0; flush = 1'b0;
    wb_WEN = 1'b0; wb_wsel = '0; wb_wdat = '0; ex_dREN = 1'b0; ex_wsel = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Reset state: all registers read zero, halt clear, zero instruction is SLL r0.
    expect_val("rst.halted", S_HALT, 32'd0);
    expect_ctrl("rst.sll0", 4'b1000, 5'b0, exv(ALU_SLL, 1'b0, 2'b01, 1'b0));
    check_all();
    for (int i = 0; i < 32; i++) begin
      instr_in = rtype(5'(i), 5'(i), 5'd1, F_ADDU);
      expect_val($sformatf("rst.r%0d.a", i), S_R1, 32'd0);
      expect_val($sformatf("rst.r%0d.b", i), S_R2, 32'd0);
      check_all();
    end

    // Write with same-cycle bypass, then stored value.
    @(negedge CLK);
    wb_WEN = 1'b1; wb_wsel = 5'd5; wb_wdat = 32'hDEADBEEF;
    instr_in = rtype(5'd5, 5'd5, 5'd1, F_ADDU);
    expect_val("byp.r5.a", S_R1, 32'hDEADBEEF);
    expect_val("byp.r5.b", S_R2, 32'hDEADBEEF);
    check_all();
    @(negedge CLK);
    wb_WEN = 1'b1; wb_wsel = 5'd7; wb_wdat = 32'h12345678;
    instr_in = rtype(5'd5, 5'd7, 5'd1, F_ADDU);
    expect_val("store.r5", S_R1, 32'hDEADBEEF);
    expect_val("byp.r7", S_R2, 32'h12345678);
    check_all();
    @(negedge CLK);
    wb_WEN = 1'b1; wb_wsel = 5'd0; wb_wdat = 32'hFFFFFFFF;
    instr_in = rtype(5'd0, 5'd7, 5'd1, F_ADDU);
    expect_val("r0.byp", S_R1, 32'd0);
    expect_val("store.r7", S_R2, 32'h12345678);
    check_all();
    @(negedge CLK);
    wb_WEN = 1'b0;
    expect_val("r0.after", S_R1, 32'd0);
    check_all();

    // Passthroughs.
    npc_in = 32'h0040_0010;
    instr_in = {OP_J, 26'h2AB_CDEF};
    expect_val("npc", S_NPC, 32'h0040_0010);
    expect_val("addr", S_ADDR, 32'h02AB_CDEF);
    check_all();

    // Decode sweep.
    sweep("addu", rtype(5'd1, 5'd2, 5'd3, F_ADDU), 4'b1000, 5'b0, exv(ALU_ADD, 1'b0, 2'b01, 1'b0));
    sweep("subu", rtype(5'd1, 5'd2, 5'd3, F_SUBU), 4'b1000, 5'b0, exv(ALU_SUB, 1'b0, 2'b01, 1'b0));
    sweep("and",  rtype(5'd1, 5'd2, 5'd3, F_AND),  4'b1000, 5'b0, exv(ALU_AND, 1'b0, 2'b01, 1'b0));
    sweep("or",   rtype(5'd1, 5'd2, 5'd3, F_OR),   4'b1000, 5'b0, exv(ALU_OR,  1'b0, 2'b01, 1'b0));
    sweep("xor",  rtype(5'd1, 5'd2, 5'd3, F_XOR),  4'b1000, 5'b0, exv(ALU_XOR, 1'b0, 2'b01, 1'b0));
    sweep("nor",  rtype(5'd1, 5'd2, 5'd3, F_NOR),  4'b1000, 5'b0, exv(ALU_NOR, 1'b0, 2'b01, 1'b0));
    sweep("slt",  rtype(5'd1, 5'd2, 5'd3, F_SLT),  4'b1000, 5'b0, exv(ALU_SLT, 1'b0, 2'b01, 1'b0));
    sweep("sltu", rtype(5'd1, 5'd2, 5'd3, F_SLTU), 4'b1000, 5'b0, exv(ALU_SLTU, 1'b0, 2'b01, 1'b0));
    sweep("srl",  rtype(5'd0, 5'd2, 5'd3, F_SRL),  4'b1000, 5'b0, exv(ALU_SRL, 1'b0, 2'b01, 1'b0));
    sweep("jr",   rtype(5'd31, 5'd0, 5'd0, F_JR),  4'b0000, 5'b00001, 8'd0);
    sweep("rbad", rtype(5'd1, 5'd2, 5'd3, 6'h3D),  4'b0000, 5'b0, 8'd0);
    sweep("addiu", itype(OP_ADDIU, 5'd1, 5'd2, 16'h8000), 4'b1000, 5'b0, exv(ALU_ADD, 1'b1, 2'b00, 1'b1));
    sweep("andi",  itype(OP_ANDI,  5'd1, 5'd2, 16'h00FF), 4'b1000, 5'b0, exv(ALU_AND, 1'b1, 2'b00, 1'b0));
    sweep("ori",   itype(OP_ORI,   5'd1, 5'd2, 16'h00FF), 4'b1000, 5'b0, exv(ALU_OR,  1'b1, 2'b00, 1'b0));
    sweep("xori",  itype(OP_XORI,  5'd1, 5'd2, 16'h00FF), 4'b1000, 5'b0, exv(ALU_XOR, 1'b1, 2'b00, 1'b0));
    sweep("lui",   itype(OP_LUI,   5'd0, 5'd2, 16'h1234), 4'b1000, 5'b0, exv(ALU_LUI, 1'b1, 2'b00, 1'b0));
    sweep("slti",  itype(OP_SLTI,  5'd1, 5'd2, 16'hFFFF), 4'b1000, 5'b0, exv(ALU_SLT, 1'b1, 2'b00, 1'b1));
    sweep("sltiu", itype(OP_SLTIU, 5'd1, 5'd2, 16'hFFFF), 4'b1000, 5'b0, exv(ALU_SLTU, 1'b1, 2'b00, 1'b1));
    sweep("lw",    itype(OP_LW,    5'd1, 5'd2, 16'h0004), 4'b1100, 5'b10000, exv(ALU_ADD, 1'b1, 2'b00, 1'b1));
    sweep("sw",    itype(OP_SW,    5'd1, 5'd2, 16'h0004), 4'b0000, 5'b01000, exv(ALU_ADD, 1'b1, 2'b00, 1'b1));
    sweep("beq",   itype(OP_BEQ,   5'd1, 5'd2, 16'hFFFE), 4'b0000, 5'b00100, exv(ALU_SUB, 1'b0, 2'b00, 1'b1));
    sweep("bne",   itype(OP_BNE,   5'd1, 5'd2, 16'hFFFE), 4'b0000, 5'b00010, exv(ALU_SUB, 1'b0, 2'b00, 1'b1));
    sweep("j",     {OP_J,   26'h0000_100}, 4'b0000, 5'b0, 8'd0);
    sweep("jal",   {OP_JAL, 26'h0000_100}, 4'b1010, 5'b0, exv(ALU_SLL, 1'b0, 2'b10, 1'b0));
    sweep("opbad", {6'h3E,  26'h3FF_FFFF}, 4'b0000, 5'b0, 8'd0);

    // Load-use hazard.
    ex_dREN = 1'b1; ex_wsel = 5'd3;
    instr_in = rtype(5'd3, 5'd2, 5'd4, F_ADDU);
    expect_val("lu.rs.stall", S_STALL, 32'd1);
    expect_ctrl("lu.rs", 4'b0, 5'b0, 8'd0);
    expect_val("lu.rs.rdat", S_R1, 32'd0);
    check_all();
    ex_wsel = 5'd0;
    instr_in = rtype(5'd0, 5'd2, 5'd4, F_ADDU);
    expect_val("lu.r0.stall", S_STALL, 32'd0);
    expect_val("lu.r0.wb", S_WB, 32'b1000);
    check_all();
    ex_wsel = 5'd3;
    instr_in = rtype(5'd2, 5'd3, 5'd4, F_ADDU);
    expect_val("lu.rt.stall", S_STALL, 32'd1);
    check_all();
    instr_in = itype(OP_ADDIU, 5'd2, 5'd3, 16'h0001);
    expect_val("lu.addiu.stall", S_STALL, 32'd0);
    expect_val("lu.addiu.wb", S_WB, 32'b1000);
    check_all();
    instr_in = itype(OP_SW, 5'd2, 5'd3, 16'h0000);
    expect_val("lu.sw.stall", S_STALL, 32'd1);
    expect_val("lu.sw.mem", S_MEM, 32'd0);
    check_all();
    instr_in = {OP_JAL, 5'd3, 5'd3, 16'h0000};
    expect_val("lu.jal.stall", S_STALL, 32'd0);
    expect_val("lu.jal.wb", S_WB, 32'b1010);
    check_all();
    ex_dREN = 1'b0;
    instr_in = rtype(5'd3, 5'd2, 5'd4, F_ADDU);
    expect_val("lu.noload.stall", S_STALL, 32'd0);
    check_all();

    // Flush squashes controls; a flushed HALT does not set halted.
    @(negedge CLK);
    ihit = 1'b1; flush = 1'b1;
    instr_in = {OP_HALT, 26'd0};
    expect_ctrl("flush.halt", 4'b0, 5'b0, 8'd0);
    check_all();
    @(negedge CLK);
    flush = 1'b0;
    instr_in = rtype(5'd5, 5'd7, 5'd1, F_ADDU);
    expect_val("flush.halted", S_HALT, 32'd0);
    expect_val("flush.after.wb", S_WB, 32'b1000);
    check_all();

    // HALT with ihit low must not latch.
    @(negedge CLK);
    ihit = 1'b0;
    instr_in = {OP_HALT, 26'd0};
    expect_val("noihit.wb", S_WB, 32'b0001);
    check_all();
    @(negedge CLK);
    expect_val("noihit.halted", S_HALT, 32'd0);
    check_all();

    // Sticky halt.
    ihit = 1'b1;
    expect_ctrl("halt", 4'b0001, 5'b0, 8'd0);
    expect_val("halt.pre", S_HALT, 32'd0);
    check_all();
    @(negedge CLK);
    instr_in = rtype(5'd5, 5'd7, 5'd1, F_ADDU);
    expect_val("halt.set", S_HALT, 32'd1);
    expect_ctrl("halt.bubble", 4'b0, 5'b0, 8'd0);
    expect_val("halt.rdat1", S_R1, 32'hDEADBEEF);
    expect_val("halt.rdat2", S_R2, 32'h12345678);
    check_all();
    @(negedge CLK);
    expect_val("halt.sticky", S_HALT, 32'd1);
    check_all();

    // Reset clears halted and registers; a write in the reset cycle is dropped.
    RST = 1'b1; wb_WEN = 1'b1; wb_wsel = 5'd9; wb_wdat = 32'h0000_0055;
    @(negedge CLK);
    RST = 1'b0; wb_WEN = 1'b0;
    instr_in = rtype(5'd9, 5'd5, 5'd1, F_ADDU);
    expect_val("rst2.halted", S_HALT, 32'd0);
    expect_val("rst2.r9", S_R1, 32'd0);
    expect_val("rst2.r5", S_R2, 32'd0);
    expect_val("rst2.wb", S_WB, 32'b1000);
    check_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the five-stage MIPS pipeline, sitting between the IF/ID latch and the ID/EX latch. Holds the 32x32 register file with write-through bypass from writeback. Decodes the instruction into the WBctrl/MEMctrl/EXctrl bundles that the ID/EX latch captures. Detects load-use hazards, inserts bubbles, and tracks a sticky halt flag.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`word_t` = 32 bits, `aluop_t` = 4 bits).
- Clocking: one clock; reset is synchronous and active-high.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- ihit  in  1  pipeline advance enable; register-file writes are not gated by it.
- instr_in  in  32  instruction from IF/ID.
- npc_in  in  32  PC+4 from IF/ID.
- flush  in  1  branch/jump squash; forces a bubble on the outputs.
- wb_WEN  in  1  writeback write enable.
- wb_wsel  in  5  writeback destination register.
- wb_wdat  in  32  writeback data.
- ex_dREN  in  1  the instruction now in EX is a load (MEMctrl_out[4] of ID/EX).
- ex_wsel  in  5  destination register of the instruction in EX.
- rdat1, rdat2  out  32 each  rs/rt read data, bypassed.
- npc_out  out  32  npc_in passthrough.
- addr_out  out  26  instr_in[25:0].
- WBctrl  out  4  {regwrite, memtoreg, link, halt}.
- MEMctrl  out  5  {dREN, dWEN, beq, bne, jr}.
- EXctrl  out  8  {aluop[3:0], alusrc, regdst[1:0] (00 rt, 01 rd, 10 r31), extop (1 = sign-extend)}.
- stall  out  1  load-use hazard; IF/ID and PC must hold.
- halted  out  1  sticky halt-decoded flag.

## Operation
- Register file:
  - 31 writable 32-bit registers; r0 reads 0 always and writes to it are dropped.
  - Write occurs on the rising edge when wb_WEN=1 and wb_wsel!=0.
- Bypass: a read whose index equals wb_wsel, with wb_WEN=1 and wb_wsel!=0, returns wb_wdat in the same cycle.
- Decode is combinational from instr_in. Supported:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, JR.
  - I-type: ADDIU, ANDI, ORI, XORI, LUI, SLTI, SLTIU, LW, SW, BEQ, BNE.
  - J-type: J, JAL.
  - HALT (opcode 6'h3F).
  - Unknown opcode/funct decodes to all control bits 0 (NOP).
- Per-instruction controls:
  - ANDI/ORI/XORI/LUI: extop=0; all other immediates sign-extend.
  - JAL: regwrite=1, link=1, regdst=10.
  - LW: dREN=1, memtoreg=1, regwrite=1, regdst=00, alusrc=1, aluop=ALU_ADD.
  - SW: dWEN=1, alusrc=1, aluop=ALU_ADD.
  - Branches: aluop=ALU_SUB.
- Hazard:
  - Condition: stall=1 when ex_dREN=1, ex_wsel!=0, and ex_wsel equals rs (for instructions reading rs) or rt (R-type, SW, BEQ, BNE only).
  - J, JAL and HALT never stall.
- Bubble: when stall=1, flush=1, or halted=1, WBctrl, MEMctrl and EXctrl are forced to 0. rdat, npc_out and addr_out still pass through.
- Halt:
  - halted is set on the rising edge when ihit=1, flush=0, stall=0 and the opcode is HALT.
  - The halting instruction itself emits WBctrl.halt=1 in that cycle.
  - halted clears only on RST.

## Timing
- Reset (RST=1 at an edge): all 31 registers become 0 and halted becomes 0.
  - The outputs depend on instr_in, so a zero instruction yields SLL r0 with regwrite=1, regdst=01 — harmless because r0 writes are dropped.
  - stall=0 unless the ex_* inputs request a stall.
  - A write presented in the same cycle as RST is discarded (RST wins).
- Read latency: 0 cycles (combinational). Write latency: visible to a read one edge later, or in the same cycle via the bypass.
- A load-use stall lasts exactly one cycle for a single dependent load: the next edge moves a bubble into EX, which clears ex_dREN.
- flush and stall together: bubble output. stall stays asserted; the upstream hazard logic gives flush priority.
- ihit=0: outputs are still driven; halted cannot set.

## Test plan
- Reset then read all: RST for 2 cycles, then rs=rt=0..31 → rdat1=rdat2=0, halted=0.
- Write/bypass:
  - wb_WEN=1, wb_wsel=5, wb_wdat=0xDEADBEEF with instr ADDU r1,r5,r5 in the same cycle → rdat1=rdat2=0xDEADBEEF.
  - Next cycle with wb_WEN=0 → still 0xDEADBEEF.
  - A write to r0 of 0xFFFFFFFF → r0 reads 0.
- Decode sweep: each supported opcode → exact bundles.
  - LW → WBctrl=4'b1100, MEMctrl=5'b10000, EXctrl={ALU_ADD,1,00,1}.
  - ORI → extop=0.
  - JAL → WBctrl=4'b1010, regdst=10.
- Load-use:
  - ex_dREN=1, ex_wsel=3, instr ADDU r4,r3,r2 → stall=1, all ctrl 0.
  - Same inputs with ex_wsel=0 → stall=0.
  - ADDIU r3 as rt-only user with ex_wsel=3 on rt → stall=0.
- Halt sticky:
  - HALT with ihit=1 → that cycle WBctrl=4'b0001; halted=1 after the edge.
  - Subsequent ADDU → ctrl 0 while halted=1.
  - RST → halted=0.
- Flush + halt: HALT with flush=1 → halted stays 0, ctrl 0.
